memory_copy_dma: RTL

MEMORY_COPY_DMA -- requirements
Module: memory_copy_dma

---
 rtl/memory_copy_dma_if.sv | 25 ++
 rtl/memory_copy_dma.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/memory_copy_dma_if.sv
// Memory-side bus of the copy DMA: registered address/write data/write
// enable from the engine, combinational read data back from the memory map.
interface memory_copy_dma_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/memory_copy_dma.sv
// Word-by-word memory copy engine (read one word, write one word).
// Optional block-fill mode is compiled in with `define MEMORY_COPY_FILL_EN.
module memory_copy_dma #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  src_addr,
  input  logic [ADDR_WIDTH-1:0]  dst_addr,
  input  logic [COUNT_WIDTH-1:0] count,
`ifdef MEMORY_COPY_FILL_EN
  input  logic                   fill,
  input  logic [DATA_WIDTH-1:0]  fill_data,
`endif
  memory_copy_dma_if.master      bus,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] words_left
);

  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDR_WIDTH-1:0]  src_ptr;
  logic [ADDR_WIDTH-1:0]  src_nxt;
  logic [ADDR_WIDTH-1:0]  dst_ptr;
  logic [ADDR_WIDTH-1:0]  dst_nxt;
  logic [ADDR_WIDTH-1:0]  addr_nxt;
  logic [DATA_WIDTH-1:0]  wdata_nxt;
  logic [COUNT_WIDTH-1:0] left_nxt;
  logic                   we_nxt;
  logic                   busy_nxt;
  logic                   done_nxt;
  logic                   fill_mode;
  logic                   fill_mode_nxt;
  logic                   start_fill;
  logic [DATA_WIDTH-1:0]  start_data;

`ifdef MEMORY_COPY_FILL_EN
  assign start_fill = fill;
  assign start_data = fill_data;
`else
  assign start_fill = 1'b0;
  assign start_data = {DATA_WIDTH{1'b0}};
`endif

  // State, pointers and all bus/status outputs are registered together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      src_ptr       <= {ADDR_WIDTH{1'b0}};
      dst_ptr       <= {ADDR_WIDTH{1'b0}};
      fill_mode     <= 1'b0;
      words_left    <= {COUNT_WIDTH{1'b0}};
      bus.mem_addr  <= {ADDR_WIDTH{1'b0}};
      bus.mem_wdata <= {DATA_WIDTH{1'b0}};
      bus.mem_we    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      src_ptr       <= src_nxt;
      dst_ptr       <= dst_nxt;
      fill_mode     <= fill_mode_nxt;
      words_left    <= left_nxt;
      bus.mem_addr  <= addr_nxt;
      bus.mem_wdata <= wdata_nxt;
      bus.mem_we    <= we_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

  // Next state plus the output values the next state will present;
  // mem_wdata doubles as the holding register between RD and WR
  always_comb begin
    state_nxt     = state;
    src_nxt       = src_ptr;
    dst_nxt       = dst_ptr;
    fill_mode_nxt = fill_mode;
    left_nxt      = words_left;
    addr_nxt      = bus.mem_addr;
    wdata_nxt     = bus.mem_wdata;
    we_nxt        = 1'b0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count != {COUNT_WIDTH{1'b0}}) begin
            src_nxt       = src_addr;
            dst_nxt       = dst_addr;
            left_nxt      = count;
            fill_mode_nxt = start_fill;
            busy_nxt      = 1'b1;
            if (start_fill) begin
              wdata_nxt = start_data;
              addr_nxt  = dst_addr;
              we_nxt    = 1'b1;
              state_nxt = WR;
            end else begin
              addr_nxt  = src_addr;
              state_nxt = RD;
            end
          end else begin
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      RD: begin
        wdata_nxt = bus.mem_rdata;
        addr_nxt  = dst_ptr;
        we_nxt    = 1'b1;
        busy_nxt  = 1'b1;
        state_nxt = WR;
      end
      WR: begin
        src_nxt  = src_ptr + ADDR_ONE;
        dst_nxt  = dst_ptr + ADDR_ONE;
        left_nxt = words_left - COUNT_ONE;
        if (words_left == COUNT_ONE) begin
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          busy_nxt = 1'b1;
          if (fill_mode) begin
            addr_nxt  = dst_ptr + ADDR_ONE;
            we_nxt    = 1'b1;
            state_nxt = WR;
          end else begin
            addr_nxt  = src_ptr + ADDR_ONE;
            state_nxt = RD;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
